// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative signed mult/madd/msub and div (one bit
// per cycle on magnitudes), plus single-cycle mfhi/mflo/mthi/mtlo moves.
module hilo_muldiv_unit (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [4:0]         ALUCtl,
  input  logic signed [31:0] A,
  input  logic signed [31:0] B,
  output logic               Busy,
  output logic               Done,
  output logic [31:0]        Result,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  localparam int DATA_W = 32;
  localparam int STAGES = 32;

  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MFHI = 5'b10000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MFLO = 5'b10010;
  localparam logic [4:0] OP_MTLO = 5'b10011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t state, state_nxt;

  logic [4:0]          cnt;
  logic                last_iter;
  logic [4:0]          op_q;
  logic                prod_neg;
  logic                rem_neg;
  logic [63:0]         mcand;
  logic [63:0]         prod;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   dvsr;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  logic [63:0]         prod_step;
  logic [63:0]         prod_signed;
  logic [63:0]         mul_res;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_diff;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   quo_step;
  logic [DATA_W-1:0]   quo_final;
  logic [DATA_W-1:0]   rem_final;

  logic                req;
  logic                is_mul_op;
  logic                accept_mul;
  logic                accept_div;
  logic                single_op;

  // Magnitude as unsigned; -2^31 maps to 2^31, which fits in 32 unsigned bits.
  function automatic logic [31:0] mag32(input logic signed [31:0] x);
    logic [31:0] u;
    u = x;
    return x[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic logic [31:0] sign_fix32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] sign_fix64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign req        = (state == IDLE) && Start;
  assign is_mul_op  = (ALUCtl == OP_MULT) || (ALUCtl == OP_MADD) || (ALUCtl == OP_MSUB);
  assign accept_mul = req && is_mul_op;
  assign accept_div = req && (ALUCtl == OP_DIV) && (B != 32'sd0);
  assign single_op  = req && ((ALUCtl == OP_MFHI) || (ALUCtl == OP_MTHI) ||
                              (ALUCtl == OP_MFLO) || (ALUCtl == OP_MTLO) ||
                              ((ALUCtl == OP_DIV) && (B == 32'sd0)));
  assign last_iter  = (cnt == 5'(STAGES - 1));
  assign Busy       = (state == MUL) || (state == DIV);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_mul)      state_nxt = MUL;
        else if (accept_div) state_nxt = DIV;
      end
      MUL, DIV: begin
        if (last_iter) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt  <= 5'd0;
      Done <= 1'b0;
    end else begin
      cnt  <= Busy ? cnt + 5'd1 : 5'd0;
      Done <= single_op || (Busy && last_iter);
    end
  end

  // Iteration step: one multiplier bit and one quotient bit per cycle
  always_comb begin
    prod_step   = mplier[0] ? prod + mcand : prod;
    prod_signed = sign_fix64(prod_step, prod_neg);
    case (op_q)
      OP_MADD: mul_res = {HI, LO} + prod_signed;
      OP_MSUB: mul_res = {HI, LO} - prod_signed;
      default: mul_res = prod_signed;
    endcase

    // rem < divisor <= 2^31, so the shifted remainder never reaches bit 32 and
    // bit 32 of the difference is a clean borrow flag.
    rem_shift = {rem, quo[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, dvsr};
    rem_step  = rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
    quo_step  = {quo[DATA_W-2:0], ~rem_diff[DATA_W]};
    quo_final = sign_fix32(quo_step, prod_neg);
    rem_final = sign_fix32(rem_step, rem_neg);
  end

  always_ff @(posedge Clk) begin
    if (req) begin
      mcand    <= {32'd0, mag32(A)};
      mplier   <= mag32(B);
      prod     <= 64'd0;
      prod_neg <= A[31] ^ B[31];
      rem_neg  <= A[31];
      op_q     <= ALUCtl;
      dvsr     <= mag32(B);
      quo      <= mag32(A);
      rem      <= '0;
    end else if (state == MUL) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (state == DIV) begin
      rem <= rem_step;
      quo <= quo_step;
    end
  end

  // Architectural HI/LO/Result: written only on completion or a move
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HI     <= 32'd0;
      LO     <= 32'd0;
      Result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (ALUCtl)
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              OP_MFHI: Result <= HI;
              OP_MFLO: Result <= LO;
              OP_DIV: begin
                if (B == 32'sd0) begin
                  HI     <= A;
                  LO     <= 32'hFFFF_FFFF;
                  Result <= 32'hFFFF_FFFF;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (last_iter) begin
            {HI, LO} <= mul_res;
            Result   <= mul_res[31:0];
          end
        end
        DIV: begin
          if (last_iter) begin
            HI     <= rem_final;
            LO     <= quo_final;
            Result <= quo_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed cases plus random ops checked
// against a 64-bit arithmetic reference model.
module tb_hilo_muldiv_unit;

  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MFHI = 5'b10000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MFLO = 5'b10010;
  localparam logic [4:0] OP_MTLO = 5'b10011;
  localparam logic [4:0] OP_ADD  = 5'b00010;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [4:0]  ALUCtl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic [31:0] HI;
  logic [31:0] LO;

  hilo_muldiv_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUCtl(ALUCtl), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] when;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo, m_res;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [4:0] pick_op(input int i);
    case (i)
      0: return OP_MULT;
      1: return OP_DIV;
      2: return OP_MADD;
      3: return OP_MSUB;
      4: return OP_MFHI;
      5: return OP_MTHI;
      6: return OP_MFLO;
      7: return OP_MTLO;
      8: return OP_ADD;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model: plain signed 64-bit arithmetic on the architectural state.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit iter, output bit valid);
    longint sa, sbv, p, q, r;
    logic [63:0] acc;
    sa    = longint'($signed(a));
    sbv   = longint'($signed(b));
    acc   = {m_hi, m_lo};
    iter  = 1'b0;
    valid = 1'b1;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB: begin
        p = sa * sbv;
        if (op == OP_MADD)      acc = acc + p;
        else if (op == OP_MSUB) acc = acc - p;
        else                    acc = p;
        m_hi  = acc[63:32];
        m_lo  = acc[31:0];
        m_res = m_lo;
        iter  = 1'b1;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          m_hi  = a;
          m_lo  = 32'hFFFF_FFFF;
          m_res = 32'hFFFF_FFFF;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
          m_lo  = q[31:0];
          m_hi  = r[31:0];
          m_res = m_lo;
          iter  = 1'b1;
        end
      end
      OP_MFHI: m_res = m_hi;
      OP_MFLO: m_res = m_lo;
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: valid = 1'b0;
    endcase
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit iter, valid;
    exp_t e;
    model(op, a, b, iter, valid);
    e.when = cyc + (iter ? 33 : 1);
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.res  = m_res;
    if (valid) sb.push_back(e);
    Start = 1'b1; ALUCtl = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (iter) begin
      for (int k = 0; k < 32; k++) begin
        @(negedge Clk);
        chk("busy_run", {31'd0, Busy}, 32'd1);
        A = $urandom;
        B = $urandom;
        if ($urandom_range(0, 7) == 0) begin
          Start  = 1'b1;
          ALUCtl = pick_op($urandom_range(0, 7));
        end else begin
          Start = 1'b0;
        end
      end
      @(negedge Clk);
      Start = 1'b0;
      chk("busy_fin", {31'd0, Busy}, 32'd0);
      @(posedge Clk); #1;
    end else begin
      @(negedge Clk);
      chk("busy_single", {31'd0, Busy}, 32'd0);
    end
  endtask

  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        got = sb.pop_front();
        chk("done_cycle", cyc, got.when);
        chk("done_hi", HI, got.hi);
        chk("done_lo", LO, got.lo);
        chk("done_result", Result, got.res);
      end
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b1; ALUCtl = OP_MTHI; A = 32'h123; B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);

    Reset = 1'b0;
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFEB);
    chk("mult_result", Result, 32'hFFFF_FFEB);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(OP_MADD, 32'd1, 32'd1);
    chk("madd_hi", HI, 32'd1);
    chk("madd_lo", LO, 32'd0);
    issue(OP_MSUB, 32'd1, 32'd1);
    chk("msub_hi", HI, 32'd0);
    chk("msub_lo", LO, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'd5, 32'd0);
    chk("div0_hi", HI, 32'd5);
    chk("div0_lo", LO, 32'hFFFF_FFFF);
    issue(OP_MFHI, 32'd0, 32'd0);
    chk("mfhi_result", Result, 32'd5);

    issue(OP_ADD, 32'd9, 32'd9);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("add_hi", HI, m_hi);
      chk("add_lo", LO, m_lo);
    end

    // Abort a running mult with reset; an mtlo during the run must be ignored
    Start = 1'b1; ALUCtl = OP_MULT; A = $urandom; B = $urandom;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Start = 1'b1; ALUCtl = OP_MTLO; A = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
    @(negedge Clk);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    chk("abort_result", Result, 32'd0);
    repeat (30) @(posedge Clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      issue(pick_op($urandom_range(0, 9)), pick_val(), pick_val());
    end

    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("pending_ops", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
